// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and control-field layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    localparam int unsigned M_BRANCH   = 2;
    localparam int unsigned M_MEMREAD  = 1;
    localparam int unsigned M_MEMWRITE = 0;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, memory freeze, branch flush,
// plus saturating performance counters and a sticky freeze-timeout flag.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FREEZE_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout,
    output logic [1:0]       state_o
);

    localparam int unsigned TW = $clog2(FREEZE_MAX + 1);
    localparam logic [TW-1:0] TimerMax = TW'(FREEZE_MAX);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          lu_hazard;
    logic          stall_inc, freeze_inc, flush_inc;

    assign lu_hazard = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        stall_inc   = 1'b0;
        freeze_inc  = 1'b0;
        flush_inc   = 1'b0;
        state_d     = ST_RUN;
        timer_d     = '0;
        err_d       = err_q;

        if (mem_busy) begin
            // Hold everything; a pending branch re-presents once memory is ready.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze_inc = 1'b1;
            state_d    = ST_FREEZE;
            if (state_q != ST_FREEZE) begin
                timer_d = TW'(1);
            end else if (timer_q == TimerMax) begin
                timer_d = timer_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = ST_FLUSH;
        end else if (lu_hazard && (state_q != ST_LU_STALL)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = ST_LU_STALL;
        end

        if (timer_d == TimerMax) begin
            err_d = 1'b1;
        end

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_inc),
        .count (freeze_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign err_timeout = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl against an event-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W      = 5;
    localparam int unsigned FREEZE_MAX = 8;
    localparam int          CMAX       = (1 << CNT_W) - 1;

    // Event classes the model reasons in.
    localparam int EV_RESET = 0;
    localparam int EV_HOLD  = 1;
    localparam int EV_FLUSH = 2;
    localparam int EV_STALL = 3;
    localparam int EV_NONE  = 4;

    logic             clk;
    logic             rst;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_uses_rt;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             err_timeout;
    logic [1:0]       state_o;

    hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_flush  (exmem_flush),
        .stall_cnt    (stall_cnt),
        .freeze_cnt   (freeze_cnt),
        .flush_cnt    (flush_cnt),
        .err_timeout  (err_timeout),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (state numbers as visible on state_o).
    bit m_valid = 0;
    int m_state, m_stall, m_freeze, m_flush, m_timer;
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_event();
        bit lu;
        lu = idex_memread && (idex_rt != 0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        if (rst) return EV_RESET;
        if (mem_busy) return EV_HOLD;
        if (branch_taken) return EV_FLUSH;
        if (lu && m_state != 1) return EV_STALL;
        return EV_NONE;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
    function automatic int ctl_for(input int ev);
        case (ev)
            EV_RESET: return 5'b00111;
            EV_HOLD:  return 5'b00000;
            EV_FLUSH: return 5'b11111;
            EV_STALL: return 5'b00010;
            default:  return 5'b11000;
        endcase
    endfunction

    function automatic int dut_ctl();
        return int'({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    endfunction

    always @(posedge clk) begin
        int ev;
        ev = cur_event();
        if (ev == EV_RESET) begin
            m_valid = 1; m_state = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
            m_timer = 0; m_err = 0;
        end else if (m_valid) begin
            case (ev)
                EV_HOLD: begin
                    if (m_freeze < CMAX) m_freeze++;
                    m_timer = (m_state == 2) ? ((m_timer < FREEZE_MAX) ? m_timer + 1 : m_timer) : 1;
                    if (m_timer == FREEZE_MAX) m_err = 1;
                    m_state = 2;
                end
                EV_FLUSH: begin
                    if (m_flush < CMAX) m_flush++;
                    m_state = 3; m_timer = 0;
                end
                EV_STALL: begin
                    if (m_stall < CMAX) m_stall++;
                    m_state = 1; m_timer = 0;
                end
                default: begin
                    m_state = 0; m_timer = 0;
                end
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst) chk("ctl_reset", dut_ctl(), ctl_for(EV_RESET));
        if (m_valid) begin
            chk("ctl", dut_ctl(), ctl_for(cur_event()));
            chk("state", int'(state_o), m_state);
            chk("stall_cnt", int'(stall_cnt), m_stall);
            chk("freeze_cnt", int'(freeze_cnt), m_freeze);
            chk("flush_cnt", int'(flush_cnt), m_flush);
            chk("err_timeout", int'(err_timeout), int'(m_err));
        end
    end

    task automatic drive(input bit r, input bit mr, input int rt, input int rs, input int irt,
                         input bit uses, input bit br, input bit busy);
        rst = r; idex_memread = mr; idex_rt = 5'(rt); ifid_rs = 5'(rs); ifid_rt = 5'(irt);
        ifid_uses_rt = uses; branch_taken = br; mem_busy = busy;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_next();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        to_next();
        idle();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("lit_rst_ctl", dut_ctl(), 5'b00111);
        to_next();
        idle();
        to_neg();
        chk("lit_rst_state", int'(state_o), 0);
        chk("lit_rst_cnt", int'(stall_cnt) + int'(freeze_cnt) + int'(flush_cnt), 0);
        to_next();

        // Load-use on rs: one stall cycle only.
        drive(0, 1, 5, 5, 0, 0, 0, 0);
        to_neg(); chk("lit_lu_rs_ctl", dut_ctl(), 5'b00010);
        to_next();
        to_neg(); chk("lit_lu_rs_next", dut_ctl(), 5'b11000);
        chk("lit_lu_rs_cnt", int'(stall_cnt), 1);
        to_next();
        idle();
        to_neg(); chk("lit_lu_rs_run", int'(state_o), 0);
        to_next();

        // rt hazard gating and register $0.
        drive(0, 1, 7, 3, 7, 0, 0, 0);
        to_neg(); chk("lit_rt_nouse", dut_ctl(), 5'b11000);
        to_next();
        drive(0, 1, 7, 3, 7, 1, 0, 0);
        to_neg(); chk("lit_rt_use", dut_ctl(), 5'b00010);
        to_next();
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        to_neg(); chk("lit_r0", dut_ctl(), 5'b11000);
        to_next();

        // Branch beats load-use.
        reset_pulse();
        drive(0, 1, 5, 5, 0, 0, 1, 0);
        to_neg(); chk("lit_br_lu_ctl", dut_ctl(), 5'b11111);
        to_next();
        idle();
        to_neg();
        chk("lit_br_state", int'(state_o), 3);
        chk("lit_br_flush", int'(flush_cnt), 1);
        chk("lit_br_stall", int'(stall_cnt), 0);
        to_next();
        to_neg(); chk("lit_br_run", int'(state_o), 0);
        to_next();

        // Freeze with branch held: branch fires on release.
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1);
            to_neg(); chk("lit_frz_ctl", dut_ctl(), 5'b00000);
            to_next();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        to_neg();
        chk("lit_frz_release", dut_ctl(), 5'b11111);
        chk("lit_frz_cnt", int'(freeze_cnt), 4);
        to_next();
        idle();
        to_next();

        // Timeout after FREEZE_MAX freeze cycles, sticky until reset.
        reset_pulse();
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            to_neg(); chk("lit_to_err", int'(err_timeout), (k > FREEZE_MAX) ? 1 : 0);
            to_next();
        end
        idle();
        to_neg(); chk("lit_to_sticky", int'(err_timeout), 1);
        to_next();
        reset_pulse();
        to_neg();
        chk("lit_to_clr", int'(err_timeout), 0);
        chk("lit_to_cnt", int'(freeze_cnt), 0);
        to_next();

        // Reset mid-freeze.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        to_next(); to_next();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        to_neg(); chk("lit_rstfrz_ctl", dut_ctl(), 5'b00111);
        to_next();
        idle();
        to_neg();
        chk("lit_rstfrz_state", int'(state_o), 0);
        chk("lit_rstfrz_cnt", int'(freeze_cnt), 0);
        to_next();

        // Random traffic; narrow register range to make hazards frequent.
        for (int c = 0; c < 4000; c++) begin
            int busy_run;
            drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 99) == 0) begin
                busy_run = $urandom_range(6, 12);
                rst = 0;
                for (int k = 0; k < busy_run; k++) begin
                    mem_busy = 1;
                    branch_taken = $urandom_range(0, 1);
                    to_next();
                end
            end else begin
                to_next();
            end
        end

        idle();
        to_next();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
